// File: rtl/reg_bank_wr.sv
// reg_bank_wr: 32 x 32-bit register bank with a sticky destination-range error flag and a one-entry write trace.
// Optional macro REG_BANK_BYPASS_EN enables a same-cycle write-through bypass on both read ports.
module reg_bank_wr #(
   parameter logic [31:0] SP_RESET = 32'd227,
   parameter int unsigned NREGS    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write,
   input  logic [31:0] wr_index,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rd_index_a,
   input  logic [4:0]  rd_index_b,
   output logic [31:0] rd_data_a,
   output logic [31:0] rd_data_b,
   output logic        idx_err,
   output logic        last_wr_valid,
   output logic [4:0]  last_wr_index,
   output logic [31:0] last_wr_data
);

   localparam logic [4:0] SP_IDX = 5'd29;

   logic [31:0] bank_q [NREGS];
   logic [31:0] bank_d [NREGS];

   logic        idx_err_q, idx_err_d;
   logic        last_wr_valid_q, last_wr_valid_d;
   logic [4:0]  last_wr_index_q, last_wr_index_d;
   logic [31:0] last_wr_data_q, last_wr_data_d;

   logic [4:0]  wr_addr_s;
   logic        wr_hi_nz_s;
   logic        wr_commit_s;
   logic        wr_range_err_s;
   logic [31:0] rd_a_s;
   logic [31:0] rd_b_s;

   function automatic logic [31:0] reset_value(input logic [4:0] idx);
      if (idx == SP_IDX) begin
         reset_value = SP_RESET;
      end else begin
         reset_value = 32'd0;
      end
   endfunction

   // Write qualification: an index-0 write is dropped silently, a non-zero upper index is an error.
   always_comb begin
      wr_addr_s      = wr_index[4:0];
      wr_hi_nz_s     = (wr_index[31:5] != 27'd0);
      wr_commit_s    = reg_write & ~wr_hi_nz_s & (wr_addr_s != 5'd0);
      wr_range_err_s = reg_write & wr_hi_nz_s;
   end

   // Next-state register contents
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         if (wr_commit_s && (wr_addr_s == 5'(i))) begin
            bank_d[i] = wr_data;
         end else begin
            bank_d[i] = bank_q[i];
         end
      end
      bank_d[0] = 32'd0;
   end

   // Next-state error flag and write trace
   always_comb begin
      idx_err_d = idx_err_q | wr_range_err_s;
      if (wr_commit_s) begin
         last_wr_valid_d = 1'b1;
         last_wr_index_d = wr_addr_s;
         last_wr_data_d  = wr_data;
      end else begin
         last_wr_valid_d = last_wr_valid_q;
         last_wr_index_d = last_wr_index_q;
         last_wr_data_d  = last_wr_data_q;
      end
   end

   // State registers; an asserted reset discards any write pending on the same edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            bank_q[i] <= reset_value(5'(i));
         end
         idx_err_q       <= 1'b0;
         last_wr_valid_q <= 1'b0;
         last_wr_index_q <= 5'd0;
         last_wr_data_q  <= 32'd0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            bank_q[i] <= bank_d[i];
         end
         idx_err_q       <= idx_err_d;
         last_wr_valid_q <= last_wr_valid_d;
         last_wr_index_q <= last_wr_index_d;
         last_wr_data_q  <= last_wr_data_d;
      end
   end

   // Read port A; the bypass path only exists when the write actually commits
   always_comb begin
      if (rd_index_a == 5'd0) begin
         rd_a_s = 32'd0;
`ifdef REG_BANK_BYPASS_EN
      end else if (wr_commit_s && (rd_index_a == wr_addr_s)) begin
         rd_a_s = wr_data;
`endif
      end else begin
         rd_a_s = bank_q[rd_index_a];
      end
   end

   // Read port B, same rules as port A
   always_comb begin
      if (rd_index_b == 5'd0) begin
         rd_b_s = 32'd0;
`ifdef REG_BANK_BYPASS_EN
      end else if (wr_commit_s && (rd_index_b == wr_addr_s)) begin
         rd_b_s = wr_data;
`endif
      end else begin
         rd_b_s = bank_q[rd_index_b];
      end
   end

   assign rd_data_a     = rd_a_s;
   assign rd_data_b     = rd_b_s;
   assign idx_err       = idx_err_q;
   assign last_wr_valid = last_wr_valid_q;
   assign last_wr_index = last_wr_index_q;
   assign last_wr_data  = last_wr_data_q;

endmodule

// File: tb/tb_reg_bank_wr.sv
// tb_reg_bank_wr: directed and random stimulus against a behavioural register-file model,
// with expectations queued at issue time and compared by an independent monitor.
module tb_reg_bank_wr;

   logic        clk = 1'b0;
   logic        reset;
   logic        reg_write;
   logic [31:0] wr_index;
   logic [31:0] wr_data;
   logic [4:0]  rd_index_a;
   logic [4:0]  rd_index_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        idx_err;
   logic        last_wr_valid;
   logic [4:0]  last_wr_index;
   logic [31:0] last_wr_data;

   always #5 clk = ~clk;

   reg_bank_wr #(.SP_RESET(32'd227), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .reg_write(reg_write), .wr_index(wr_index),
      .wr_data(wr_data), .rd_index_a(rd_index_a), .rd_index_b(rd_index_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .idx_err(idx_err),
      .last_wr_valid(last_wr_valid), .last_wr_index(last_wr_index),
      .last_wr_data(last_wr_data)
   );

   // behavioural model of the architectural state
   logic [31:0] m_regs [32];
   logic        m_err;
   logic        m_lv;
   logic [4:0]  m_li;
   logic [31:0] m_ld;

   typedef struct {
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
      m_err = 1'b0;
      m_lv  = 1'b0;
      m_li  = 5'd0;
      m_ld  = 32'd0;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] ra);
      if (ra == 5'd0) return 32'd0;
`ifdef REG_BANK_BYPASS_EN
      if (reset && reg_write && (wr_index >= 32'd1) && (wr_index <= 32'd31)
          && (ra == wr_index[4:0])) return wr_data;
`endif
      return m_regs[ra];
   endfunction

   task automatic push_expect();
      exp_q.push_back('{0, model_read(rd_index_a)});
      exp_q.push_back('{1, model_read(rd_index_b)});
      exp_q.push_back('{2, {31'd0, m_err}});
      exp_q.push_back('{3, {31'd0, m_lv}});
      exp_q.push_back('{4, {27'd0, m_li}});
      exp_q.push_back('{5, m_ld});
   endtask

   // drive one cycle of stimulus, queue its expectations, then apply the edge to the model
   task automatic step(input logic we, input logic [31:0] idx, input logic [31:0] data,
                       input logic [4:0] a, input logic [4:0] b);
      reg_write  = we;
      wr_index   = idx;
      wr_data    = data;
      rd_index_a = a;
      rd_index_b = b;
      push_expect();
      @(posedge clk);
      if (reset && we) begin
         if (idx > 32'd31) begin
            m_err = 1'b1;
         end else if (idx != 32'd0) begin
            m_regs[idx] = data;
            m_lv = 1'b1;
            m_li = idx[4:0];
            m_ld = data;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      step(1'b1, 32'd7, 32'hCAFE_0007, 5'd29, 5'd7);
      reset = 1'b1;
   endtask

   // monitor: compare DUT outputs against queued expectations away from the active edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         string       nm;
         e = exp_q.pop_front();
         case (e.kind)
            0: begin act = rd_data_a;              nm = "rd_data_a"; end
            1: begin act = rd_data_b;              nm = "rd_data_b"; end
            2: begin act = {31'd0, idx_err};       nm = "idx_err"; end
            3: begin act = {31'd0, last_wr_valid}; nm = "last_wr_valid"; end
            4: begin act = {27'd0, last_wr_index}; nm = "last_wr_index"; end
            default: begin act = last_wr_data;     nm = "last_wr_data"; end
         endcase
         n_checks++;
         if (act === e.exp) begin
            n_pass++;
         end else begin
            $display("FAIL %s t=%0t ra=%0d rb=%0d actual=%h expected=%h",
                     nm, $time, rd_index_a, rd_index_b, act, e.exp);
         end
      end
   end

   initial begin
      logic [31:0] r;
      logic [31:0] idx;
      logic [4:0]  a;
      logic [4:0]  b;
      logic        we;

      reset = 1'b0;
      reg_write = 1'b0;
      wr_index = 32'd0;
      wr_data = 32'd0;
      rd_index_a = 5'd0;
      rd_index_b = 5'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 16; i++) step(1'b0, 32'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));

      step(1'b1, 32'd31, 32'hDEADBEEF, 5'd31, 5'd0);
      step(1'b0, 32'd0, 32'd0, 5'd31, 5'd31);

      step(1'b1, 32'd0, 32'h0000_1234, 5'd0, 5'd0);
      step(1'b0, 32'd0, 32'd0, 5'd0, 5'd0);

      step(1'b1, 32'h0000_0025, 32'd7, 5'd5, 5'd5);
      step(1'b0, 32'd0, 32'd0, 5'd5, 5'd5);
      step(1'b1, 32'd3, 32'h0000_00AA, 5'd3, 5'd5);
      step(1'b0, 32'd0, 32'd0, 5'd3, 5'd0);

      @(posedge clk);
      #1;
      do_reset();
      step(1'b0, 32'd0, 32'd0, 5'd7, 5'd31);

      step(1'b1, 32'd29, 32'd100, 5'd29, 5'd29);
      step(1'b0, 32'd0, 32'd0, 5'd29, 5'd0);

      step(1'b0, 32'hFFFF_FFFF, 32'h55, 5'd31, 5'd29);
      step(1'b0, 32'd0, 32'd0, 5'd31, 5'd29);

      for (int n = 0; n < 400; n++) begin
         if (n % 100 == 99) do_reset();
         r = $urandom();
         we = (r[1:0] != 2'd0);
         case (r[5:2])
            4'd0:    idx = 32'd0;
            4'd1:    idx = {r[31:6] | 26'd1, 1'b0, r[10:6]};
            default: idx = 32'($urandom_range(1, 31));
         endcase
         a = 5'($urandom_range(0, 31));
         b = 5'($urandom_range(0, 31));
         if (r[12]) a = idx[4:0];
         if (r[13]) b = idx[4:0];
         step(we, idx, $urandom(), a, b);
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_wr.md
Name: reg_bank_wr

Overview:
- 32 x 32-bit general-purpose register bank for the multicycle CPU, directly downstream of the register-destination select mux.
- Takes the 32-bit destination index produced by that mux, plus write data and write enable from the control unit. Provides two combinational read ports to the A/B operand latches.
- Adds sticky destination-range checking and a one-entry write trace for debug.

Parameters:
- SP_RESET, 32'd227, reset value of register 29 (stack pointer).
- NREGS, 32, number of architectural registers (fixed at 32; parameter is for documentation and assertions only).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable for this cycle.
- wr_index  input  32  destination index from the regDst mux; only [4:0] addresses the bank.
- wr_data  input  32  write data (from the memToReg path).
- rd_index_a  input  5  read port A index (rs).
- rd_index_b  input  5  read port B index (rt).
- rd_data_a  output  32  read port A data.
- rd_data_b  output  32  read port B data.
- idx_err  output  1  sticky flag: a write was attempted with wr_index[31:5] non-zero.
- last_wr_valid  output  1  high once at least one write has committed since reset.
- last_wr_index  output  5  index of the most recent committed write.
- last_wr_data  output  32  data of the most recent committed write.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-to-clk deassert use):
  - all registers clear to 0, except register 29, which loads SP_RESET;
  - idx_err=0, last_wr_valid=0, last_wr_index=0, last_wr_data=0.
- Write commit: on the rising clk edge when reg_write=1 and wr_index[31:5]==0 and wr_index[4:0]!=0.
  - bank[wr_index[4:0]] <= wr_data;
  - last_wr_valid <= 1, last_wr_index <= wr_index[4:0], last_wr_data <= wr_data.
- Register 0 is hardwired to zero.
  - A write to index 0 is discarded silently: no trace update, no error.
  - Reads of index 0 always return 0.
- Out-of-range index: reg_write=1 with wr_index[31:5]!=0.
  - The write is suppressed and the trace is unchanged.
  - idx_err <= 1 and stays set until reset.
  - This covers mux encodings outside the legal set (0 is returned on invalid select and is handled as an index-0 write, not an error).
- reg_write=0: wr_index and wr_data are ignored completely, including for error checking.
- Reads: combinational, zero latency. rd_data_x = bank[rd_index_x], subject to the index-0 rule.
  - A read of the same index being written in the current cycle returns the OLD value; the new value is visible after the edge. The optional feature changes this.
- Reset asserted mid-cycle overrides any pending write; the write is lost.
- Only one write per cycle; there are no simultaneous-write conflicts.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: write-through bypass. If reg_write=1, the write would commit this edge, and rd_index_x==wr_index[4:0], then rd_data_x returns wr_data combinationally in the same cycle.
  - Index 0 and out-of-range writes are never bypassed.
- Undefined: read-old-value behaviour as above, with no bypass mux.

Test Plan:
- Reset check: assert reset low mid-operation → all reads return 0 except index 29 = 227; idx_err=0; last_wr_valid=0.
- Normal write and read: reg_write=1, wr_index=32'd31, wr_data=32'hDEADBEEF, one edge, then rd_index_a=31 → rd_data_a=32'hDEADBEEF; last_wr_index=31; last_wr_valid=1.
- Index 0: write 32'h1234 to wr_index=0 → rd_data_b at index 0 stays 0; trace and idx_err unchanged.
- Out-of-range index: reg_write=1, wr_index=32'h0000_0025, wr_data=7 → register 5 unchanged; idx_err=1 and stays 1 across later legal writes until reset.
- Same-cycle read-during-write at index 29 with wr_data=32'd100:
  - macro undefined → rd_data_a=227 before the edge and 100 after;
  - macro defined → rd_data_a=100 in the same cycle.
- Enable gating: reg_write=0 with wr_index=32'hFFFF_FFFF → no register change; idx_err stays 0.
